grant_locked_mux: RTL
=====================

# grant_locked_mux

Packet-aware payload multiplexer placed directly downstream of a one-hot request/grant arbiter, such as the static-priority or timeout static-priority arbiters. It presents input valids to the arbiter as requests and routes the granted channel's valid/data/last onto a single output valid/ready stream. Once a beat is offered, it locks the grant until a `last` beat transfers, so multi-beat packets are never interleaved and the output stays stable under backpressure.

## Interface
- `SIZE`, 4: number of input channels (≥2).
- `WIDTH`, 8: payload width in bits.

- `clock`  input  1  system clock.
- `resetn`  input  1  asynchronous, active-low reset.
- `input_valid`  input  SIZE  per-channel beat valid.
- `input_data`  input  SIZE*WIDTH  per-channel payload; channel i occupies bits [i*WIDTH +: WIDTH].
- `input_last`  input  SIZE  per-channel end-of-packet flag.
- `input_ready`  output  SIZE  per-channel ready; at most one bit is set.
- `arbiter_requests`  output  SIZE  request vector driven to the external arbiter.
- `arbiter_grant`  input  SIZE  one-hot grant from the external arbiter, combinational from `arbiter_requests`.
- `output_valid`  output  1  muxed beat valid.
- `output_data`  output  WIDTH  muxed payload.
- `output_last`  output  1  muxed end-of-packet flag.
- `output_ready`  input  1  downstream ready.

## Operation
- Two-state FSM:
  - IDLE: no grant is locked.
  - LOCKED: `locked_grant` register holds a one-hot channel.
- Active selection:
  - In IDLE, `select = arbiter_grant & input_valid`.
  - In LOCKED, `select = locked_grant`.
- `arbiter_requests`:
  - IDLE: equals `input_valid`.
  - LOCKED: all zeros. This freezes arbiter aging and grant-based countdown resets for the length of the packet.
- Mux outputs:
  - `mux_valid = |(select & input_valid)`.
  - Data and last are AND-OR muxed by `select`; they are 0 when `select` is 0.
- `input_ready = select & {SIZE{sink_ready}}`.
  - `sink_ready` is `output_ready`, or the slice's ready when the slice is present (see Configuration).
- A transfer is `mux_valid & sink_ready`.
- IDLE → LOCKED when `mux_valid` is high and either:
  - there is no transfer (backpressure), or
  - the transfer is not last.
  - In both cases `locked_grant <= select`.
- IDLE → IDLE on a last-beat transfer (single-beat packet) or when `mux_valid` is low.
- LOCKED → IDLE on a transfer with `input_last` set on the locked channel. Otherwise stay in LOCKED.
- A locked channel that drops valid mid-packet produces a bubble (`mux_valid` = 0). The lock is held; no other channel is served.
- `arbiter_grant` of zero, or a grant for a non-valid channel, produces no transfer and no state change.
- `arbiter_grant` is ignored in LOCKED.
- Reset mid-packet: FSM returns to IDLE, `locked_grant` is cleared and the slice is emptied. The partial packet is not completed.

## Timing
- Reset values:
  - State is IDLE, `locked_grant` = 0.
  - `output_valid` = 0, `output_last` = 0, `output_data` = 0 (slice registers).
  - `input_ready` = 0 during reset.
- Latency without slice: 0 cycles; input to output is combinational.
- Latency with slice: 1 cycle.
- Throughput: one beat per cycle.
- Back-to-back packets without a bubble: the cycle after a last-beat transfer is in IDLE and arbitrates in that same cycle.
- Grant is decided combinationally in IDLE and registered into `locked_grant` at the clock edge.
- Output stability: once `output_valid` is high, `output_valid`, `output_data` and `output_last` remain stable until `output_ready`. This is guaranteed by locking on backpressure.

## Configuration
- Macro: `GRANT_LOCKED_MUX_OUTPUT_SLICE_EN`.
- Defined:
  - A 2-entry skid buffer is inserted between the mux and the output.
  - `sink_ready` is the registered "not full" signal of the skid buffer.
  - All output ports are registered; `output_ready` has no combinational path to `input_ready` or `arbiter_requests`.
- Undefined:
  - Outputs are driven directly by the mux and `sink_ready = output_ready`.
  - A combinational path exists from `output_ready` to `input_ready`.

## Structure
- Package `grant_locked_mux_pkg` holds:
  - the FSM state encoding (`STATE_IDLE` = 1'b0, `STATE_LOCKED` = 1'b1);
  - the skid-buffer depth constant (2).
- Sub-module `skid_buffer` (WIDTH+1 bits wide, carrying data and last) is instantiated only under the macro.
- The one-hot AND-OR mux is inline; no sub-module.

## Test plan
- Single-beat packet with `output_ready` held at 1. Channel 2 valid, data 0x5A, last=1, grant 0100 → same cycle (or +1 with slice): `output_data` = 0x5A, `input_ready` = 0100, state remains IDLE.
- Four-beat packet on channel 1. Channel 0 raises valid after beat 1 and the arbiter grants 0001 → beats 2–4 still come from channel 1, `arbiter_requests` = 0000 while locked, channel 0 is served the cycle after channel 1's last beat.
- Backpressure. `output_ready` = 0 for 3 cycles on a granted beat 0xA5 of channel 3, while the arbiter grant switches to 0001 → `output_data` stays 0xA5 and `output_valid` stays 1 throughout, then the beat transfers and channel 3 stays selected.
- Back-to-back single-beat packets. Channels 1 and 2 alternate with `output_ready` = 1 → one beat per cycle, no bubbles.
- Locked channel 2 drops valid for 2 cycles mid-packet → `output_valid` = 0 for those cycles, no other channel is served, and the packet resumes on channel 2.
- Assert `resetn` = 0 mid-packet on channel 1 → state IDLE, `output_valid` = 0 and `input_ready` = 0 while `resetn` is low. After release, `arbiter_requests` equals `input_valid`.

Source files
------------

// File: rtl/grant_locked_mux_pkg.sv
// Shared definitions for grant_locked_mux: FSM state encoding and the depth
// of the optional output skid buffer.
package grant_locked_mux_pkg;

    // IDLE arbitrates every cycle; LOCKED holds one channel until its last beat.
    typedef enum logic {
        STATE_IDLE   = 1'b0,
        STATE_LOCKED = 1'b1
    } state_e;

    // Two entries let the slice take a new beat every cycle while its
    // ready is a pure register output.
    localparam int SKID_DEPTH = 2;

endpackage

// File: rtl/grant_locked_mux_skid_buffer.sv
// Two-entry skid buffer used as the optional output slice of grant_locked_mux.
// in_ready is a registered "not full", so out_ready has no combinational path
// back to the producer. Only instantiated when GRANT_LOCKED_MUX_OUTPUT_SLICE_EN
// is defined.
// Handshake: a beat moves on any cycle where valid and ready are both high;
// a producer holding valid keeps its payload stable until it moves.
module skid_buffer
    import grant_locked_mux_pkg::*;
#(
    parameter int WIDTH = 9
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    localparam int PW = $clog2(SKID_DEPTH);
    localparam int CW = $clog2(SKID_DEPTH + 1);

    logic [WIDTH-1:0] mem_q [SKID_DEPTH];
    logic [WIDTH-1:0] mem_d [SKID_DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             ready_q, ready_d;
    logic             push, pop;

    assign push      = in_valid & ready_q;
    assign pop       = (count_q != '0) & out_ready;
    assign in_ready  = ready_q;
    assign out_valid = (count_q != '0);
    assign out_data  = mem_q[rd_ptr_q];

    // Next-state of the FIFO storage, pointers, occupancy and ready flag.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            mem_d[wr_ptr_q] = in_data;
            wr_ptr_d = (wr_ptr_q == PW'(SKID_DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == PW'(SKID_DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
        end
        count_d = count_q + CW'(push) - CW'(pop);
        ready_d = (count_d != CW'(SKID_DEPTH));
    end

    // Register the buffer; storage clears on reset so the outputs read zero.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < SKID_DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ready_q  <= 1'b1;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ready_q  <= ready_d;
        end
    end

endmodule

// File: rtl/grant_locked_mux.sv
// grant_locked_mux: routes the channel granted by an external one-hot arbiter
// onto one valid/ready stream and holds that grant until a last beat moves,
// so packets never interleave and a stalled beat stays put.
// Optional feature: define GRANT_LOCKED_MUX_OUTPUT_SLICE_EN to register all
// outputs through a two-entry skid buffer (one cycle of latency).
// Handshake: a beat moves on any cycle where valid and ready are both high;
// a producer holding valid keeps its payload stable until it moves.
module grant_locked_mux
    import grant_locked_mux_pkg::*;
#(
    parameter int SIZE  = 4,
    parameter int WIDTH = 8
) (
    input  logic                  clock,
    input  logic                  resetn,
    input  logic [SIZE-1:0]       input_valid,
    input  logic [SIZE*WIDTH-1:0] input_data,
    input  logic [SIZE-1:0]       input_last,
    output logic [SIZE-1:0]       input_ready,
    output logic [SIZE-1:0]       arbiter_requests,
    input  logic [SIZE-1:0]       arbiter_grant,
    output logic                  output_valid,
    output logic [WIDTH-1:0]      output_data,
    output logic                  output_last,
    input  logic                  output_ready
);

    state_e          state_q, state_d;
    logic [SIZE-1:0] locked_grant_q, locked_grant_d;
    logic [SIZE-1:0] select;
    logic            mux_valid;
    logic            mux_valid_out;
    logic [WIDTH-1:0] mux_data;
    logic            mux_last;
    logic            sink_ready;
    logic            xfer;

    // Selection follows the arbiter while idle and the locked channel otherwise;
    // requests are withheld while locked so the arbiter's history is frozen.
    always_comb begin
        if (state_q == STATE_IDLE) begin
            select           = arbiter_grant & input_valid;
            arbiter_requests = input_valid;
        end else begin
            select           = locked_grant_q;
            arbiter_requests = '0;
        end
    end

    // One-hot AND-OR mux of data and last; all zero when nothing is selected.
    always_comb begin
        mux_data = '0;
        mux_last = 1'b0;
        for (int i = 0; i < SIZE; i++) begin
            mux_data = mux_data | (input_data[i*WIDTH +: WIDTH] & {WIDTH{select[i]}});
            mux_last = mux_last | (input_last[i] & select[i]);
        end
    end

    assign mux_valid     = |(select & input_valid);
    // Nothing is offered or accepted while reset is asserted.
    assign mux_valid_out = mux_valid & resetn;
    assign input_ready   = select & {SIZE{sink_ready & resetn}};
    assign xfer          = mux_valid & sink_ready;

`ifdef GRANT_LOCKED_MUX_OUTPUT_SLICE_EN
    logic slice_ready;

    skid_buffer #(
        .WIDTH (WIDTH + 1)
    ) u_skid_buffer (
        .clock     (clock),
        .resetn    (resetn),
        .in_valid  (mux_valid_out),
        .in_ready  (slice_ready),
        .in_data   ({mux_last, mux_data}),
        .out_valid (output_valid),
        .out_ready (output_ready),
        .out_data  ({output_last, output_data})
    );

    assign sink_ready = slice_ready;
`else
    assign sink_ready   = output_ready;
    assign output_valid = mux_valid_out;
    assign output_data  = mux_data;
    assign output_last  = mux_last;
`endif

    // Lock on any offered beat that does not complete a packet this cycle;
    // release once a last beat of the locked channel transfers.
    always_comb begin
        state_d        = state_q;
        locked_grant_d = locked_grant_q;
        case (state_q)
            STATE_IDLE: begin
                if (mux_valid && !(xfer && mux_last)) begin
                    state_d        = STATE_LOCKED;
                    locked_grant_d = select;
                end
            end
            STATE_LOCKED: begin
                if (xfer && mux_last) begin
                    state_d        = STATE_IDLE;
                    locked_grant_d = '0;
                end
            end
            default: begin
                state_d        = STATE_IDLE;
                locked_grant_d = '0;
            end
        endcase
    end

    // FSM state and locked grant registers.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q        <= STATE_IDLE;
            locked_grant_q <= '0;
        end else begin
            state_q        <= state_d;
            locked_grant_q <= locked_grant_d;
        end
    end

endmodule
